prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream program loader: the writer side of the processor's program-memory load port (wr_addr/wr_data/we).
- Accepts a framed byte stream (count, word pairs, optional checksum) over a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word into program memory and holds the processor in reset while loading.
- Sits between a host byte source (UART RX, JTAG shim) and the processor top level.

Parameters:
- START_ADDR, 8'h00, first program-memory address written; addresses wrap modulo 256.
- HOLD_ON_ERR, 1, 1 keeps cpu_hold asserted after a failed load; 0 releases it.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load when idle
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts rx_data this cycle
- wr_addr  out  8  program-memory write address
- wr_data  out  16  program-memory write data {hi,lo}
- we  out  2  program-memory byte write enables; 2'b11 for full-word write, else 2'b00
- cpu_hold  out  1  drive to processor reset; high while loading
- busy  out  1  load in progress
- done  out  1  sticky; last load completed OK
- err  out  1  sticky; last load failed checksum

Behaviour:
- Reset (reset==0 at posedge): state IDLE; rx_ready=0, we=2'b00, wr_addr=START_ADDR, wr_data=0, cpu_hold=0, busy=0, done=0, err=0; index, count, sum cleared. Reset mid-load aborts immediately; the partial image stays in memory.
- A byte transfer occurs only on a posedge with rx_valid && rx_ready. rx_data is sampled only then. rx_valid may drop at any time without effect.
- FSM states: IDLE, CNT, HI, LO, WRITE, CSUM, FIN, FAIL.
- IDLE: rx_ready=0. On start, go to CNT; set cpu_hold=1, busy=1; clear done, err, index, sum. start in any other state is ignored.
- CNT: rx_ready=1. The accepted byte becomes count; 8'h00 means 256 words. Go to HI.
- HI: rx_ready=1. The accepted byte goes to hi_reg. Go to LO.
- LO: rx_ready=1. The accepted byte goes to lo_reg. Go to WRITE.
- WRITE: exactly one cycle; rx_ready=0; we=2'b11; wr_addr=START_ADDR+index (8-bit wrap); wr_data={hi_reg,lo_reg}. Then index++. If index+1 == count (9-bit compare, 0 treated as 256), go to CSUM (macro on) or FIN; otherwise go to HI.
- Latency: write asserts on the cycle after the LO byte is accepted.
- we is 2'b00 in every state except WRITE. wr_addr/wr_data hold their last values outside WRITE.
- sum: an 8-bit running modulo-256 sum of every accepted byte, including the count byte and the checksum byte.
- FIN: cpu_hold=0, busy=0, done=1. Next state IDLE.
- FAIL: busy=0, err=1; cpu_hold = HOLD_ON_ERR ? 1 : 0. Next state IDLE. err and held cpu_hold persist until start or reset.
- There is no timeout; a stalled source leaves the loader busy indefinitely.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined: after the last WRITE the loader enters CSUM (rx_ready=1) and accepts one checksum byte. The sender chooses it so the 8-bit sum of all bytes is 0. Sum==0 goes to FIN; otherwise FAIL.
- Undefined: CSUM and FAIL are unreachable, err stays 0, and the stream ends after the last lo byte.

Decomposition:
- Shared package: state encoding localparams, the WE_FULL=2'b11 and WE_NONE=2'b00 constants, and the frame-field widths (8-bit count/address, 16-bit word).
- One natural sub-module: prog_loader_csum (8-bit accumulator with clear, add-on-accept, and is_zero output). It is instantiated only under the macro.

Test Plan:
- Basic load, macro off: start, stream 02,12,34,AB,CD -> we=11 writes 0x00=1234 then 0x01=ABCD; done=1; cpu_hold falls the cycle after the second write.
- Backpressure/gaps: same stream with rx_valid toggling randomly -> identical writes; rx_ready=0 during each WRITE; no byte lost or duplicated.
- Checksum, macro on: 01,00,0F,F0 -> done=1, err=0. Stream 01,00,0F,F1 -> err=1, done=0, and cpu_hold stays 1 with HOLD_ON_ERR=1.
- Count 0 with START_ADDR=8'hF0: 00 then 256 word pairs -> 256 writes, addresses F0..FF then 00..EF (wrap), done=1.
- Reset mid-load: drive reset=0 after the HI byte of word 3 -> next cycle all outputs at reset values, we=00, state IDLE; a fresh start reloads correctly.
- start while busy: pulse start in HI state -> ignored; index and writes unaffected.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
// Holds the FSM state encoding, write-enable constants, frame field widths
// and a helper that turns the 8-bit count byte into a word count.
package prog_loader_pkg;

  localparam int ADDR_W = 8;   // program-memory address width
  localparam int CNT_W  = 8;   // count field width in the frame
  localparam int BYTE_W = 8;   // stream byte width
  localparam int WORD_W = 16;  // instruction word width

  localparam logic [1:0] WE_FULL = 2'b11;
  localparam logic [1:0] WE_NONE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CNT   = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_FIN   = 3'd6,
    ST_FAIL  = 3'd7
  } state_t;

  // A count byte of zero stands for a full 256-word image.
  function automatic logic [CNT_W:0] words_of(input logic [CNT_W-1:0] count);
    return (count == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and program-memory write port.
//
// Handshake: a byte moves only on a rising clock edge where rx_valid and
// rx_ready are both high; rx_data is meaningful only on that edge. The
// source may raise or drop rx_valid at any time, and the loader may drop
// rx_ready at any time; neither side waits on the other combinationally.
// The write side is a plain strobe: wr_addr/wr_data are valid while we is
// WE_FULL, and hold their last values otherwise.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [1:0]        we;

  // Host byte source / memory observer side.
  modport master (
    output rx_valid, rx_data,
    input  rx_ready, wr_addr, wr_data, we
  );

  // Loader side.
  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, wr_addr, wr_data, we
  );

endinterface

// File: rtl/prog_loader_csum.sv
// prog_loader_csum: 8-bit modulo-256 running sum of accepted stream bytes.
// Only instantiated when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader_csum
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [BYTE_W-1:0] data,
  output logic              is_zero
);

  logic [BYTE_W-1:0] sum;

  // Accumulate every accepted byte; clear at the start of a load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

  // Looks ahead by including the byte now on data, so the pass/fail decision
  // can be taken in the same cycle the checksum byte is accepted.
  assign is_zero = ((sum + data) == '0);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream program loader.
// Frame: count byte (0 = 256 words), then {hi, lo} byte pairs, then an
// optional checksum byte when PROG_LOADER_CHECKSUM_EN is defined. Each word
// is written to program memory one cycle after its lo byte is accepted, and
// the processor is held in reset (cpu_hold) for the whole load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR  = 8'h00,
  parameter bit                HOLD_ON_ERR = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err,
  output state_t       dbg_state
);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [BYTE_W-1:0] hi_reg;
  logic [CNT_W:0]    index;   // one bit wider so 256 words compare cleanly
  logic              accept;
  logic              csum_ok;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign dbg_state = state;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic csum_clear;
  assign csum_clear = (state == ST_IDLE) && start;

  prog_loader_csum u_csum (
    .clk     (clk),
    .reset   (reset),
    .clear   (csum_clear),
    .add     (accept),
    .data    (bus.rx_data),
    .is_zero (csum_ok)
  );
`else
  assign csum_ok = 1'b1;
`endif

  // Frame FSM; all outputs are registered and set on entry to each state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bus.rx_ready <= 1'b0;
      bus.we       <= WE_NONE;
      bus.wr_addr  <= START_ADDR;
      bus.wr_data  <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      count        <= '0;
      hi_reg       <= '0;
      index        <= '0;
    end else begin
      bus.we <= WE_NONE;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_CNT;
            bus.rx_ready <= 1'b1;
            cpu_hold     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            index        <= '0;
          end
        end
        ST_CNT: begin
          if (accept) begin
            count <= bus.rx_data;
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (accept) begin
            hi_reg <= bus.rx_data;
            state  <= ST_LO;
          end
        end
        ST_LO: begin
          if (accept) begin
            bus.rx_ready <= 1'b0;
            bus.we       <= WE_FULL;
            bus.wr_addr  <= START_ADDR + index[ADDR_W-1:0];
            bus.wr_data  <= {hi_reg, bus.rx_data};
            state        <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          index <= index + 1'b1;
          if ((index + 1'b1) == words_of(count)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state        <= ST_CSUM;
            bus.rx_ready <= 1'b1;
`else
            state    <= ST_FIN;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
`endif
          end else begin
            state        <= ST_HI;
            bus.rx_ready <= 1'b1;
          end
        end
        ST_CSUM: begin
          if (accept) begin
            bus.rx_ready <= 1'b0;
            busy         <= 1'b0;
            if (csum_ok) begin
              state    <= ST_FIN;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= ST_FAIL;
              cpu_hold <= HOLD_ON_ERR;
              err      <= 1'b1;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        ST_FAIL: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
// Exercises the checksum paths when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam logic [7:0] START = 8'hF0;
  localparam bit         HOLD  = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   reset = 1'b0;
  logic   start = 1'b0;
  logic   cpu_hold, busy, done, err;
  state_t dbg_state;

  prog_loader_if bus ();

  prog_loader #(.START_ADDR(START), .HOLD_ON_ERR(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [23:0] exp_q[$];      // {addr, data} of each expected write
  logic [15:0] frame_w[$];    // words of the frame being sent
  int          wr_cnt = 0;
  bit          check_tail = 1'b0;
  bit          tail_pending = 1'b0;
  bit          pend_start = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every write is matched against the expected queue.
  initial begin : monitor
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (tail_pending) begin
        tail_pending = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        check_eq("hold_await_csum", cpu_hold, 1);
`else
        check_eq("hold_fall", cpu_hold, 0);
        check_eq("done_after_last", done, 1);
`endif
      end
      if (reset && bus.we != WE_NONE) begin
        check_eq("we_value", bus.we, WE_FULL);
        check_eq("rdy_in_write", bus.rx_ready, 0);
        check_eq("hold_in_write", cpu_hold, 1);
        check_eq("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("wr_addr", bus.wr_addr, e[23:16]);
          check_eq("wr_data", bus.wr_data, e[15:0]);
          if (exp_q.size() == 0 && check_tail) tail_pending = 1'b1;
        end
        wr_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit sent = 1'b0;
    int budget = 200;
    while (!sent && budget > 0) begin
      @(negedge clk);
      start        = pend_start;
      pend_start   = 1'b0;
      bus.rx_valid = ($urandom_range(0, 99) >= gap_pct);
      bus.rx_data  = bus.rx_valid ? b : 8'($urandom);
      sent         = bus.rx_valid && bus.rx_ready;
      budget--;
    end
    if (!sent) check_eq("byte_accepted", sent, 1);
    @(posedge clk);
  endtask

  task automatic idle_stream();
    @(negedge clk);
    bus.rx_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rdy"},   bus.rx_ready, 0);
    check_eq({tag, "_we"},    bus.we, WE_NONE);
    check_eq({tag, "_addr"},  bus.wr_addr, START);
    check_eq({tag, "_data"},  bus.wr_data, 0);
    check_eq({tag, "_hold"},  cpu_hold, 0);
    check_eq({tag, "_busy"},  busy, 0);
    check_eq({tag, "_done"},  done, 0);
    check_eq({tag, "_err"},   err, 0);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Sends one whole frame built from frame_w and checks the final status.
  task automatic do_load(input int n, input bit bad_csum, input int gap_pct, input bit start_mid);
    logic [7:0] sum;
    logic [7:0] cb;
    bit ok;
    int k;
    for (int i = 0; i < n; i++) exp_q.push_back({START + 8'(i), frame_w[i]});
    wr_cnt     = 0;
    check_tail = 1'b1;
    pulse_start();
    cb  = 8'(n);
    sum = cb;
    send_byte(cb, gap_pct);
    for (int i = 0; i < n; i++) begin
      if (i == 0) pend_start = start_mid;
      send_byte(frame_w[i][15:8], gap_pct);
      send_byte(frame_w[i][7:0], gap_pct);
      sum = sum + frame_w[i][15:8] + frame_w[i][7:0];
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    cb = 8'(8'h00 - sum) + (bad_csum ? 8'h01 : 8'h00);
    send_byte(cb, gap_pct);
`endif
    idle_stream();
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = !(CSUM_EN && bad_csum);
    check_eq("end_busy", busy, 0);
    check_eq("end_done", done, ok);
    check_eq("end_err", err, !ok);
    check_eq("end_hold", cpu_hold, ok ? 1'b0 : HOLD);
    check_eq("end_wr_cnt", wr_cnt, n);
    check_eq("end_q_empty", exp_q.size(), 0);
    @(negedge clk);
    check_eq("end_idle", dbg_state, ST_IDLE);
    check_eq("done_sticky", done, ok);
  endtask

  task automatic fill_random(input int n);
    frame_w.delete();
    for (int i = 0; i < n; i++) frame_w.push_back(16'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);

    // Basic two-word load, then the same stream with a gappy source.
    frame_w = '{16'h1234, 16'hABCD};
    do_load(2, 1'b0, 0, 1'b0);
    do_load(2, 1'b0, 60, 1'b0);

    // start pulsed while in HI is ignored.
    fill_random(4);
    do_load(4, 1'b0, 30, 1'b1);

`ifdef PROG_LOADER_CHECKSUM_EN
    // 01,00,0F,F0 passes; 01,00,0F,F1 fails and keeps the CPU held.
    frame_w = '{16'h000F};
    do_load(1, 1'b0, 0, 1'b0);
    do_load(1, 1'b1, 0, 1'b0);
`endif

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      fill_random(n);
      do_load(n, CSUM_EN ? 1'($urandom_range(0, 1)) : 1'b0, $urandom_range(0, 70), 1'b0);
    end

    // Count byte 0: 256 words, addresses wrap past FF.
    fill_random(256);
    do_load(256, 1'b0, 0, 1'b0);

    // Reset after the hi byte of the third word.
    fill_random(5);
    exp_q.push_back({START, frame_w[0]});
    exp_q.push_back({START + 8'd1, frame_w[1]});
    wr_cnt     = 0;
    check_tail = 1'b0;
    pulse_start();
    send_byte(8'd5, 20);
    for (int i = 0; i < 2; i++) begin
      send_byte(frame_w[i][15:8], 20);
      send_byte(frame_w[i][7:0], 20);
    end
    send_byte(frame_w[2][15:8], 20);
    @(negedge clk);
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    start        = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    check_eq("midrst_wr_cnt", wr_cnt, 2);
    check_eq("midrst_q_empty", exp_q.size(), 0);
    reset = 1'b1;
    @(negedge clk);

    fill_random(3);
    do_load(3, 1'b0, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
